iir_mc_fixed: RTL and testbench

Parametrised, time-multiplexed fixed-point IIR filter (Direct Form I, order ORDER) serving CHANNELS independent audio channels with one shared multiply-accumulate unit. It sits between the audio codec receive path and the transmit path, runs on the fast state clock, and processes one full multi-channel frame per lr_clk rising edge. Successor to the single-channel 4th-order filter: adds generic order, width and channel count, same-sample output (no extra output delay), overrun detection and optional saturation.

---
 rtl/iir_pkg.sv | 50 +++++
 rtl/iir_mac_unit.sv | 88 ++++++++
 rtl/iir_mc_fixed.sv | 264 ++++++++++++++++++++++++++
 tb/tb_iir_mc_fixed.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// iir_pkg: shared definitions for the multi-channel IIR filter.
//   - iir_state_e : frame sequencer states
//   - val_w/acc_w : internal value and accumulator width derivation
//   - ONE / one_q : Q2.(COEF_W-2) unity coefficient
//   - sat_to      : signed clamp to a given width (only used when
//                   IIR_SATURATE_EN is defined)
package iir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } iir_state_e;

  // Samples carry two guard bits below the LSB inside the datapath.
  function automatic int val_w(input int data_w);
    return data_w + 2;
  endfunction

  // Four bits of headroom above the value width for tap accumulation.
  function automatic int acc_w(input int data_w);
    return val_w(data_w) + 4;
  endfunction

  // Unity coefficient for a given coefficient width.
  function automatic longint one_q(input int coef_w);
    return longint'(64'sd1 <<< (coef_w - 2));
  endfunction

  // Unity at the default 18-bit coefficient width.
  localparam logic [17:0] ONE = 18'h10000;

  // Clamp a signed value into the range of a w-bit two's-complement number.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi_s;
    logic signed [63:0] lo_s;
    hi_s = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo_s = -hi_s - 64'sd1;
    if (v > hi_s) begin
      return hi_s;
    end else if (v < lo_s) begin
      return lo_s;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// iir_mac_unit: shared signed multiply / rescale / accumulate.
// Ports:
//   state_clk  processing clock
//   reset      synchronous active-low reset
//   clear      zero the accumulator on the next edge
//   enable     add the current tap product on the next edge
//   coef       signed Q2.(COEF_W-2) coefficient
//   value      signed VAL_W sample / history value
//   acc        registered accumulator
// With IIR_SATURATE_EN defined the rescaled product and the running sum
// clamp to ACC_W instead of wrapping.
module iir_mac_unit
  import iir_pkg::*;
#(
  parameter int COEF_W = 18,
  parameter int VAL_W  = 18,
  parameter int ACC_W  = 22
) (
  input  logic              state_clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [COEF_W-1:0] coef,
  input  logic [VAL_W-1:0]  value,
  output logic [ACC_W-1:0]  acc
);

  localparam int PROD_W = COEF_W + VAL_W;

  logic signed [PROD_W-1:0] coef_ext_s;
  logic signed [PROD_W-1:0] val_ext_s;
  logic signed [PROD_W-1:0] prod_full_s;
  logic signed [PROD_W-1:0] prod_shift_s;
  logic [ACC_W-1:0]         prod_acc_s;
  logic signed [ACC_W:0]    sum_s;
  logic [ACC_W-1:0]         acc_next_s;
  logic [ACC_W-1:0]         acc_r;
  logic                     unused_s;
`ifdef IIR_SATURATE_EN
  logic signed [63:0]       prod_sat_s;
  logic signed [63:0]       sum_sat_s;
`endif

  // Tap product rescaled back to value units, then added to the running sum.
  always_comb begin
    coef_ext_s   = {{VAL_W{coef[COEF_W-1]}}, coef};
    val_ext_s    = {{COEF_W{value[VAL_W-1]}}, value};
    prod_full_s  = coef_ext_s * val_ext_s;
    // Arithmetic shift truncates toward minus infinity.
    prod_shift_s = prod_full_s >>> (COEF_W - 2);
`ifdef IIR_SATURATE_EN
    prod_sat_s = sat_to(64'(prod_shift_s), ACC_W);
    prod_acc_s = prod_sat_s[ACC_W-1:0];
`else
    prod_acc_s = prod_shift_s[ACC_W-1:0];
`endif
    sum_s = $signed({acc_r[ACC_W-1], acc_r}) + $signed({prod_acc_s[ACC_W-1], prod_acc_s});
`ifdef IIR_SATURATE_EN
    sum_sat_s  = sat_to(64'(sum_s), ACC_W);
    acc_next_s = sum_sat_s[ACC_W-1:0];
`else
    acc_next_s = sum_s[ACC_W-1:0];
`endif
  end

  // Bits discarded by truncation/clamping.
`ifdef IIR_SATURATE_EN
  assign unused_s = ^{prod_sat_s[63:ACC_W], sum_sat_s[63:ACC_W]};
`else
  assign unused_s = ^{prod_shift_s[PROD_W-1:ACC_W], sum_s[ACC_W]};
`endif

  // Accumulator register: clear wins over enable.
  always_ff @(posedge state_clk) begin
    if (!reset) begin
      acc_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
    end else if (enable) begin
      acc_r <= acc_next_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/iir_mc_fixed.sv
// iir_mc_fixed: time-multiplexed Direct Form I IIR filter, ORDER taps,
// CHANNELS independent channels sharing one MAC (iir_mac_unit).
// Ports:
//   state_clk  processing clock (all logic on rising edge)
//   reset      synchronous active-low reset
//   lr_clk     sample-rate clock, asynchronous; rising edge starts a frame
//   audio_in   CHANNELS samples, channel c at [c*DATA_W +: DATA_W]
//   scale      left shift applied to the accumulator before storing y(n)
//   b, a       feed-forward / pre-negated feedback coefficients, Q2.(COEF_W-2)
//   audio_out  filtered samples of the current frame
//   out_valid  one-cycle pulse when audio_out updates
//   busy       high from LOAD through DONE
//   overrun    sticky, set when a sample edge arrives while busy
// Build option: define IIR_SATURATE_EN to clamp the accumulator and y(n)
// instead of wrapping.
module iir_mc_fixed
  import iir_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 18,
  parameter int ORDER    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                         state_clk,
  input  logic                         reset,
  input  logic                         lr_clk,
  input  logic [CHANNELS*DATA_W-1:0]   audio_in,
  input  logic [2:0]                   scale,
  input  logic [(ORDER+1)*COEF_W-1:0]  b,
  input  logic [ORDER*COEF_W-1:0]      a,
  output logic [CHANNELS*DATA_W-1:0]   audio_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int VAL_W = val_w(DATA_W);
  localparam int ACC_W = acc_w(DATA_W);
  localparam int NTAPS = 2 * ORDER + 1;
  localparam int TAP_W = $clog2(NTAPS);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Room for the accumulator shifted left by up to 7.
  localparam int SHF_W = ACC_W + 7;

  logic [2:0]                              lr_sync_r;
  logic                                    strobe_s;
  iir_state_e                              state_r;
  iir_state_e                              state_nx_s;
  logic [CH_W-1:0]                         ch_r;
  logic [TAP_W-1:0]                        tap_r;
  logic                                    last_tap_s;
  logic                                    last_ch_s;
  logic                                    mac_clr_s;
  logic                                    mac_en_s;
  logic [CHANNELS-1:0][VAL_W-1:0]          x_cur_r;
  logic [CHANNELS-1:0][ORDER-1:0][VAL_W-1:0] x_hist_r;
  logic [CHANNELS-1:0][ORDER-1:0][VAL_W-1:0] y_hist_r;
  logic [CHANNELS-1:0][DATA_W-1:0]         stage_r;
  logic [CHANNELS*DATA_W-1:0]              audio_out_r;
  logic                                    out_valid_r;
  logic                                    busy_r;
  logic                                    overrun_r;
  logic [VAL_W-1:0]                        row_xc_s;
  logic [ORDER-1:0][VAL_W-1:0]             row_xh_s;
  logic [ORDER-1:0][VAL_W-1:0]             row_yh_s;
  logic [COEF_W-1:0]                       coef_s;
  logic [VAL_W-1:0]                        val_s;
  logic [ACC_W-1:0]                        acc_s;
  logic signed [SHF_W-1:0]                 shift_s;
  logic [VAL_W-1:0]                        y_s;
  logic                                    unused_s;
`ifdef IIR_SATURATE_EN
  logic signed [63:0]                      y_sat_s;
`endif

  // Two-flop synchroniser for lr_clk plus a delayed copy for edge detection.
  always_ff @(posedge state_clk) begin
    if (!reset) begin
      lr_sync_r <= 3'b000;
    end else begin
      lr_sync_r <= {lr_sync_r[1:0], lr_clk};
    end
  end

  assign strobe_s   = lr_sync_r[1] & ~lr_sync_r[2];
  assign last_tap_s = (tap_r == TAP_W'(NTAPS - 1));
  assign last_ch_s  = (ch_r == CH_W'(CHANNELS - 1));

  // FSM state register.
  always_ff @(posedge state_clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (strobe_s) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD:  state_nx_s = ST_MAC;
      ST_MAC: begin
        if (last_tap_s) begin
          state_nx_s = ST_WRITE;
        end else begin
          state_nx_s = ST_MAC;
        end
      end
      ST_WRITE: begin
        if (last_ch_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_MAC;
        end
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs driving the MAC unit.
  always_comb begin
    mac_clr_s = 1'b0;
    mac_en_s  = 1'b0;
    case (state_r)
      ST_LOAD:  mac_clr_s = 1'b1;
      ST_WRITE: mac_clr_s = 1'b1;
      ST_MAC:   mac_en_s  = 1'b1;
      default: begin
        mac_clr_s = 1'b0;
        mac_en_s  = 1'b0;
      end
    endcase
  end

  // Tap mux: pick the active channel's row, then the coefficient/value pair.
  // Tap 0..ORDER walk b on x(n)..x(n-ORDER); the rest walk a on y(n-1)...
  always_comb begin
    row_xc_s = '0;
    row_xh_s = '0;
    row_yh_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      row_xc_s = (ch_r == CH_W'(c)) ? x_cur_r[c]  : row_xc_s;
      row_xh_s = (ch_r == CH_W'(c)) ? x_hist_r[c] : row_xh_s;
      row_yh_s = (ch_r == CH_W'(c)) ? y_hist_r[c] : row_yh_s;
    end
    coef_s = b[0 +: COEF_W];
    val_s  = row_xc_s;
    for (int k = 0; k < ORDER; k++) begin
      coef_s = (tap_r == TAP_W'(k + 1)) ? b[(k + 1) * COEF_W +: COEF_W] : coef_s;
      val_s  = (tap_r == TAP_W'(k + 1)) ? row_xh_s[k] : val_s;
      coef_s = (tap_r == TAP_W'(ORDER + 1 + k)) ? a[k * COEF_W +: COEF_W] : coef_s;
      val_s  = (tap_r == TAP_W'(ORDER + 1 + k)) ? row_yh_s[k] : val_s;
    end
  end

  iir_mac_unit #(
    .COEF_W (COEF_W),
    .VAL_W  (VAL_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .state_clk (state_clk),
    .reset     (reset),
    .clear     (mac_clr_s),
    .enable    (mac_en_s),
    .coef      (coef_s),
    .value     (val_s),
    .acc       (acc_s)
  );

  // y(n) = acc <<< scale reduced to VAL_W (wrapped, or clamped when saturating).
  always_comb begin
    shift_s = {{7{acc_s[ACC_W-1]}}, acc_s};
    shift_s = shift_s <<< scale;
`ifdef IIR_SATURATE_EN
    y_sat_s = sat_to(64'(shift_s), VAL_W);
    y_s     = y_sat_s[VAL_W-1:0];
`else
    y_s     = shift_s[VAL_W-1:0];
`endif
  end

`ifdef IIR_SATURATE_EN
  assign unused_s = ^{shift_s, y_sat_s[63:VAL_W]};
`else
  assign unused_s = ^shift_s[SHF_W-1:VAL_W];
`endif

  // Datapath: sample latch, tap/channel counters, histories and output staging.
  always_ff @(posedge state_clk) begin
    if (!reset) begin
      ch_r        <= '0;
      tap_r       <= '0;
      x_cur_r     <= '0;
      x_hist_r    <= '0;
      y_hist_r    <= '0;
      stage_r     <= '0;
      audio_out_r <= '0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          for (int c = 0; c < CHANNELS; c++) begin
            x_cur_r[c] <= {audio_in[c * DATA_W +: DATA_W], 2'b00};
          end
          ch_r  <= '0;
          tap_r <= '0;
        end
        ST_MAC: begin
          tap_r <= tap_r + TAP_W'(1);
        end
        ST_WRITE: begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (ch_r == CH_W'(c)) begin
              for (int k = ORDER - 1; k > 0; k--) begin
                x_hist_r[c][k] <= x_hist_r[c][k - 1];
                y_hist_r[c][k] <= y_hist_r[c][k - 1];
              end
              x_hist_r[c][0] <= x_cur_r[c];
              y_hist_r[c][0] <= y_s;
              // y_s is already clamped to VAL_W when saturating, so dropping
              // the guard bits keeps the sample inside DATA_W limits.
              stage_r[c]     <= y_s[VAL_W-1:2];
            end
          end
          ch_r  <= ch_r + CH_W'(1);
          tap_r <= '0;
        end
        ST_DONE: begin
          audio_out_r <= stage_r;
        end
        default: begin
          tap_r <= tap_r;
        end
      endcase
    end
  end

  // Status flags: out_valid follows DONE, busy tracks the next state, overrun is sticky.
  always_ff @(posedge state_clk) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      out_valid_r <= (state_r == ST_DONE);
      busy_r      <= (state_nx_s != ST_IDLE);
      overrun_r   <= overrun_r | (strobe_s & (state_r != ST_IDLE));
    end
  end

  assign audio_out = audio_out_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_iir_mc_fixed.sv
`timescale 1ns/1ps
module tb_iir_mc_fixed;

  localparam int DATA_W   = 16;
  localparam int COEF_W   = 18;
  localparam int ORDER    = 4;
  localparam int CHANNELS = 2;
  localparam int VAL_W    = DATA_W + 2;
  localparam int ACC_W    = VAL_W + 4;
`ifdef IIR_SATURATE_EN
  localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
  localparam logic [15:0] SAT_EXP = 16'hDFFF;
`endif

  logic                              state_clk = 1'b0;
  logic                              reset;
  logic                              lr_clk;
  logic [CHANNELS*DATA_W-1:0]        audio_in;
  logic [2:0]                        scale;
  logic [(ORDER+1)*COEF_W-1:0]       b;
  logic [ORDER*COEF_W-1:0]           a;
  logic [CHANNELS*DATA_W-1:0]        audio_out;
  logic                              out_valid;
  logic                              busy;
  logic                              overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: coefficients as real numbers scaled by 2^16.
  longint bc [0:ORDER];
  longint ac [0:ORDER-1];
  longint xh [0:CHANNELS-1][0:ORDER-1];
  longint yh [0:CHANNELS-1][0:ORDER-1];
  int     sc;

  always #5 state_clk = ~state_clk;

  iir_mc_fixed #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .ORDER    (ORDER),
    .CHANNELS (CHANNELS)
  ) dut (
    .state_clk (state_clk),
    .reset     (reset),
    .lr_clk    (lr_clk),
    .audio_in  (audio_in),
    .scale     (scale),
    .b         (b),
    .a         (a),
    .audio_out (audio_out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge state_clk);
    #1;
  endtask

  // Two's-complement wrap, or clamp when the saturating build is tested.
  function automatic longint fixw(input longint v, input int w);
    longint lim;
    longint m;
    lim = longint'(1) <<< (w - 1);
`ifdef IIR_SATURATE_EN
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
`else
    m = v & ((lim <<< 1) - 1);
    if (m >= lim) m = m - (lim <<< 1);
    return m;
`endif
  endfunction

  function automatic longint mulq(input longint c, input longint v);
    return (c * v) >>> (COEF_W - 2);
  endfunction

  task automatic apply_coefs();
    for (int k = 0; k <= ORDER; k++) b[k * COEF_W +: COEF_W] = bc[k][COEF_W-1:0];
    for (int k = 0; k < ORDER; k++)  a[k * COEF_W +: COEF_W] = ac[k][COEF_W-1:0];
    scale = sc[2:0];
  endtask

  task automatic set_coefs_zero();
    for (int k = 0; k <= ORDER; k++) bc[k] = 0;
    for (int k = 0; k < ORDER; k++)  ac[k] = 0;
    sc = 0;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    lr_clk = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    for (int c = 0; c < CHANNELS; c++)
      for (int k = 0; k < ORDER; k++) begin
        xh[c][k] = 0;
        yh[c][k] = 0;
      end
    cycle();
  endtask

  // Filter equation evaluated tap by tap from the difference equation.
  task automatic model_frame(input logic [15:0] s0, input logic [15:0] s1,
                             output logic [15:0] e0, output logic [15:0] e1);
    logic [15:0] s [0:1];
    logic [15:0] e [0:1];
    longint x, acc, y, r;
    s[0] = s0;
    s[1] = s1;
    for (int c = 0; c < CHANNELS; c++) begin
      x   = longint'($signed(s[c])) * 4;
      acc = fixw(mulq(bc[0], x), ACC_W);
      for (int k = 1; k <= ORDER; k++) acc = fixw(acc + fixw(mulq(bc[k], xh[c][k-1]), ACC_W), ACC_W);
      for (int k = 0; k < ORDER; k++)  acc = fixw(acc + fixw(mulq(ac[k], yh[c][k]), ACC_W), ACC_W);
      y = fixw(acc <<< sc, VAL_W);
      for (int k = ORDER - 1; k > 0; k--) begin
        xh[c][k] = xh[c][k-1];
        yh[c][k] = yh[c][k-1];
      end
      xh[c][0] = x;
      yh[c][0] = y;
      r    = y >>> 2;
      e[c] = r[15:0];
    end
    e0 = e[0];
    e1 = e[1];
  endtask

  // One lr_clk rising edge; returns outputs at out_valid and latencies.
  task automatic run_frame(input logic [15:0] s0, input logic [15:0] s1,
                           output logic [15:0] o0, output logic [15:0] o1,
                           output int lat_s, output int lat_f, output logic ok);
    audio_in = {s1, s0};
    lr_clk   = 1'b1;
    lat_s    = 0;
    lat_f    = 0;
    ok       = 1'b1;
    while (!busy && lat_s < 20) begin
      cycle();
      lat_s++;
    end
    if (!busy) ok = 1'b0;
    while (!out_valid && lat_f < 100) begin
      cycle();
      lat_f++;
    end
    if (!out_valid) ok = 1'b0;
    o0     = audio_out[15:0];
    o1     = audio_out[31:16];
    lr_clk = 1'b0;
    cycle();
  endtask

  task automatic frame_const(input string tag, input logic [15:0] s0, input logic [15:0] s1,
                             input logic [15:0] x0, input logic [15:0] x1);
    logic [15:0] o0, o1;
    int ls, lf;
    logic ok;
    run_frame(s0, s1, o0, o1, ls, lf, ok);
    check({tag, "_done"}, 32'(ok), 32'd1);
    check({tag, "_ch0"}, 32'(o0), 32'(x0));
    check({tag, "_ch1"}, 32'(o1), 32'(x1));
    repeat (3) cycle();
  endtask

  initial begin
    logic [15:0] o0, o1, e0, e1, r0, r1;
    int ls, lf, pulses;
    logic ok;

    audio_in = '0;
    scale    = 3'd0;
    b        = '0;
    a        = '0;
    set_coefs_zero();
    reset  = 1'b0;
    lr_clk = 1'b0;
    repeat (3) cycle();
    check("rst_audio_out", audio_out, 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    do_reset();

    // Pass-through with latency measurement.
    bc[0] = 64'h10000;
    apply_coefs();
    run_frame(16'h1234, 16'h0000, o0, o1, ls, lf, ok);
    check("pass_done", 32'(ok), 32'd1);
    check("pass_ch0", 32'(o0), 32'h1234);
    check("pass_strobe_lat", 32'(ls), 32'd3);
    check("pass_frame_lat", 32'(lf), 32'd22);
    check("pass_pulse_width", 32'(out_valid), 32'd0);
    check("pass_busy_low", 32'(busy), 32'd0);
    check("pass_hold", 32'(audio_out[15:0]), 32'h1234);
    repeat (3) cycle();

    // Pure one-sample delay.
    do_reset();
    set_coefs_zero();
    bc[1] = 64'h10000;
    apply_coefs();
    frame_const("delay0", 16'h0100, 16'h0000, 16'h0000, 16'h0000);
    frame_const("delay1", 16'h0200, 16'h0000, 16'h0100, 16'h0000);

    // First-order recursion, pole at 0.5.
    do_reset();
    set_coefs_zero();
    bc[0] = 64'h10000;
    ac[0] = 64'h08000;
    apply_coefs();
    frame_const("rec0", 16'h4000, 16'h0000, 16'h4000, 16'h0000);
    frame_const("rec1", 16'h0000, 16'h0000, 16'h2000, 16'h0000);
    frame_const("rec2", 16'h0000, 16'h0000, 16'h1000, 16'h0000);
    frame_const("rec3", 16'h0000, 16'h0000, 16'h0800, 16'h0000);

    // Channel isolation: impulse on ch1 only.
    do_reset();
    frame_const("iso0", 16'h0000, 16'h4000, 16'h0000, 16'h4000);
    frame_const("iso1", 16'h0000, 16'h0000, 16'h0000, 16'h2000);

    // Gain near 2.0 overflows the output range.
    do_reset();
    set_coefs_zero();
    bc[0] = 64'h1FFFF;
    apply_coefs();
    frame_const("sat", 16'h7000, 16'h0000, SAT_EXP, 16'h0000);

    // Randomised coefficients and samples against the reference model.
    do_reset();
    for (int k = 0; k <= ORDER; k++) bc[k] = longint'($urandom_range(0, 32767)) - 16384;
    for (int k = 0; k < ORDER; k++)  ac[k] = longint'($urandom_range(0, 16383)) - 8192;
    sc = int'($urandom_range(0, 1));
    apply_coefs();
    for (int f = 0; f < 12; f++) begin
      r0 = 16'($urandom());
      r1 = 16'($urandom());
      model_frame(r0, r1, e0, e1);
      run_frame(r0, r1, o0, o1, ls, lf, ok);
      check("rand_done", 32'(ok), 32'd1);
      check($sformatf("rand%0d_ch0", f), 32'(o0), 32'(e0));
      check($sformatf("rand%0d_ch1", f), 32'(o1), 32'(e1));
      repeat (3) cycle();
    end
    check("no_overrun_normal", 32'(overrun), 32'd0);

    // Second sample edge 10 cycles after the first.
    do_reset();
    set_coefs_zero();
    bc[0] = 64'h10000;
    apply_coefs();
    audio_in = {16'h0000, 16'h0042};
    lr_clk   = 1'b1;
    repeat (5) cycle();
    lr_clk = 1'b0;
    repeat (5) cycle();
    lr_clk = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (out_valid) pulses++;
    end
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_one_pulse", 32'(pulses), 32'd1);
    check("ovr_frame_out", 32'(audio_out[15:0]), 32'h0042);
    lr_clk = 1'b0;
    do_reset();
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Reset in the middle of MAC aborts the frame.
    audio_in = {16'h0000, 16'h1111};
    lr_clk   = 1'b1;
    ls = 0;
    while (!busy && ls < 20) begin
      cycle();
      ls++;
    end
    check("abort_started", 32'(busy), 32'd1);
    repeat (4) cycle();
    reset = 1'b0;
    repeat (2) cycle();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_audio_out", audio_out, 32'h0);
    lr_clk = 1'b0;
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (out_valid) pulses++;
    end
    check("abort_no_valid", 32'(pulses), 32'd0);
    check("abort_out_zero", audio_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
